// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad. One column at a time is pulled
//   low (the others float), the synchronised rows are sampled at the end of
//   each column dwell, and once all four columns have been visited the scan
//   result (no key / one key / several keys) drives a debounce FSM. An
//   accepted key produces a one-cycle key_valid strobe with its code.
//
//   Optional build macro: KEYPAD_REPEAT_EN
//     When defined, a held key re-strobes key_valid after REPEAT_DELAY_SCANS
//     matching scans and then every REPEAT_RATE_SCANS matching scans.
//     When undefined, there is exactly one strobe per press and no repeat
//     logic exists.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   key_row    in   4  keypad rows, active low, asynchronous to clk
//   key_col    out  4  keypad columns, active column driven 0, others high-Z
//   key_valid  out  1  one-cycle strobe, key_code valid in the same cycle
//   key_code   out  4  {row_idx, col_idx} of the last accepted key
//   key_held   out  1  high while the accepted key is debounced-pressed
module keypad_scanner #(
  parameter int SCAN_DIV           = 1000,
  parameter int DEBOUNCE_SCANS     = 4,
  parameter int REPEAT_DELAY_SCANS = 200,
  parameter int REPEAT_RATE_SCANS  = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      key_row,
  output wire logic [3:0] key_col,
  output logic            key_valid,
  output logic [3:0]      key_code,
  output logic            key_held
);

  localparam int             DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [15:0]    DEB_N    = 16'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 ||
      REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2
  } state_t;

  logic [3:0]    r_row_sync_p0;
  logic [3:0]    r_row_sync_p1;
  logic [DW-1:0] r_div;
  logic [1:0]    r_col_idx;
  logic [1:0]    r_hit_cnt;
  logic [3:0]    r_hit_code;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cand;
  logic [3:0]    w_cand_nxt;
  logic [15:0]   r_match;
  logic [15:0]   w_match_nxt;
  logic [15:0]   r_rel;
  logic [15:0]   w_rel_nxt;
  logic [3:0]    r_code;
  logic [3:0]    w_code_nxt;
  logic          r_valid;
  logic          w_strobe;

  logic [3:0]    w_row_low;
  logic [1:0]    w_col_hits;
  logic [1:0]    w_row_idx;
  logic [2:0]    w_hit_sum;
  logic [1:0]    w_tot;
  logic [3:0]    w_code_now;
  logic          w_last;
  logic          w_scan_done;
  logic          w_one;
  logic          w_none;
  logic [15:0]   w_match_inc;
  logic [15:0]   w_rel_inc;

`ifdef KEYPAD_REPEAT_EN
  logic [15:0]   r_rep_cnt;
  logic [15:0]   w_rep_nxt;
  logic          r_rep_first;
  logic          w_rep_first_nxt;
  logic [15:0]   w_rep_inc;
  logic [15:0]   w_rep_target;

  assign w_rep_inc    = r_rep_cnt + 16'd1;
  assign w_rep_target = r_rep_first ? 16'(REPEAT_DELAY_SCANS) : 16'(REPEAT_RATE_SCANS);
`endif

  // Only the active column is pulled low; the pull-ups own the rest.
  assign key_col = (r_col_idx == 2'd0) ? 4'bzzz0 :
                   (r_col_idx == 2'd1) ? 4'bzz0z :
                   (r_col_idx == 2'd2) ? 4'bz0zz : 4'b0zzz;

  assign w_row_low = ~r_row_sync_p1;

  // Per-column classification: 0 = none, 1 = single row, 2 = several rows.
  always_comb begin
    w_col_hits = 2'd0;
    w_row_idx  = 2'd0;
    case (w_row_low)
      4'b0000: w_col_hits = 2'd0;
      4'b0001: begin w_col_hits = 2'd1; w_row_idx = 2'd0; end
      4'b0010: begin w_col_hits = 2'd1; w_row_idx = 2'd1; end
      4'b0100: begin w_col_hits = 2'd1; w_row_idx = 2'd2; end
      4'b1000: begin w_col_hits = 2'd1; w_row_idx = 2'd3; end
      default: w_col_hits = 2'd2;
    endcase
  end

  // Running key count across the scan saturates at 2 (MULTI).
  assign w_hit_sum   = {1'b0, r_hit_cnt} + {1'b0, w_col_hits};
  assign w_tot       = (w_hit_sum >= 3'd2) ? 2'd2 : w_hit_sum[1:0];
  assign w_code_now  = (r_hit_cnt == 2'd0) ? {w_row_idx, r_col_idx} : r_hit_code;
  assign w_last      = (r_div == DIV_LAST);
  assign w_scan_done = w_last && (r_col_idx == 2'd3);
  assign w_one       = w_scan_done && (w_tot == 2'd1);
  assign w_none      = w_scan_done && (w_tot == 2'd0);
  assign w_match_inc = r_match + 16'd1;
  assign w_rel_inc   = r_rel + 16'd1;

  // Stage p0/p1: two-flop row synchroniser, then column scan bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_sync_p0 <= 4'hF;
      r_row_sync_p1 <= 4'hF;
      r_div         <= '0;
      r_col_idx     <= 2'd0;
      r_hit_cnt     <= 2'd0;
      r_hit_code    <= 4'h0;
    end else begin
      r_row_sync_p0 <= key_row;
      r_row_sync_p1 <= r_row_sync_p0;
      if (w_last) begin
        r_div     <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        if (r_col_idx == 2'd3) begin
          r_hit_cnt  <= 2'd0;
          r_hit_code <= 4'h0;
        end else begin
          r_hit_cnt  <= w_tot;
          r_hit_code <= w_code_now;
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  // Debounce FSM: at most one transition per completed scan.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_match_nxt = r_match;
    w_rel_nxt   = r_rel;
    w_code_nxt  = r_code;
    w_strobe    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nxt       = r_rep_cnt;
    w_rep_first_nxt = r_rep_first;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_one) begin
          w_cand_nxt  = w_code_now;
          w_match_nxt = 16'd1;
          if (DEB_N <= 16'd1) begin
            w_state_nxt = S_PRESSED;
            w_code_nxt  = w_code_now;
            w_rel_nxt   = 16'd0;
            w_strobe    = 1'b1;
          end else begin
            w_state_nxt = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (w_one) begin
          if (w_code_now == r_cand) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc >= DEB_N) begin
              w_state_nxt = S_PRESSED;
              w_code_nxt  = r_cand;
              w_rel_nxt   = 16'd0;
              w_strobe    = 1'b1;
            end
          end else begin
            w_cand_nxt  = w_code_now;
            w_match_nxt = 16'd1;
          end
        end else if (w_scan_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRESSED: begin
        // A different key or several keys leave the state untouched:
        // the held key must be released before another is accepted.
        if (w_one && (w_code_now == r_code)) begin
          w_rel_nxt = 16'd0;
`ifdef KEYPAD_REPEAT_EN
          if (w_rep_inc >= w_rep_target) begin
            w_strobe        = 1'b1;
            w_rep_nxt       = 16'd0;
            w_rep_first_nxt = 1'b0;
          end else begin
            w_rep_nxt = w_rep_inc;
          end
`endif
        end else if (w_none) begin
          w_rel_nxt = w_rel_inc;
          if (w_rel_inc >= DEB_N) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef KEYPAD_REPEAT_EN
    if (w_state_nxt != S_PRESSED) begin
      w_rep_nxt       = 16'd0;
      w_rep_first_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stage p2: FSM datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand  <= 4'h0;
      r_match <= 16'd0;
      r_rel   <= 16'd0;
      r_code  <= 4'h0;
      r_valid <= 1'b0;
    end else begin
      r_cand  <= w_cand_nxt;
      r_match <= w_match_nxt;
      r_rel   <= w_rel_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_strobe;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_cnt   <= 16'd0;
      r_rep_first <= 1'b1;
    end else begin
      r_rep_cnt   <= w_rep_nxt;
      r_rep_first <= w_rep_first_nxt;
    end
  end
`endif

  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign key_held  = (r_state == S_PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a strobe scoreboard.
// A small keypad model answers the scanned column with row levels; expected
// key codes are queued when a press is applied and checked on each strobe.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int RDELAY   = 3;
  localparam int RRATE    = 2;
  localparam int SCAN     = 4 * SCAN_DIV;
  localparam int LAT_MAX  = (DEB + 1) * SCAN + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_row;
  wire  [3:0] key_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  int         mode = 0;      // 0: no key, 1: key 6 pressed, 2: keys 6 and 9 pressed
  int         tests = 0;
  int         fails = 0;
  int         n;
  logic [3:0] exp_q[$];
  logic [2:0] col_dec;
  logic       prev_valid = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV          (SCAN_DIV),
    .DEBOUNCE_SCANS    (DEB),
    .REPEAT_DELAY_SCANS(RDELAY),
    .REPEAT_RATE_SCANS (RRATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  // Which column is being driven; 7 means an illegal column pattern.
  assign col_dec = (key_col === 4'bzzz0) ? 3'd0 :
                   (key_col === 4'bzz0z) ? 3'd1 :
                   (key_col === 4'bz0zz) ? 3'd2 :
                   (key_col === 4'b0zzz) ? 3'd3 : 3'd7;

  // Keypad model: key 6 = row 1 / col 2, key 9 = row 2 / col 1.
  always_comb begin
    key_row = 4'hF;
    if ((mode == 1 || mode == 2) && col_dec == 3'd2) key_row = 4'b1101;
    else if (mode == 2 && col_dec == 3'd1)           key_row = 4'b1011;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_scan_start();
    logic [2:0] prev;
    int         c;
    prev = col_dec;
    c    = 0;
    do begin
      @(negedge clk);
      c++;
      if (prev == 3'd3 && col_dec == 3'd0) break;
      prev = col_dec;
    end while (c < 4 * SCAN);
    chk("scan_start", col_dec, 0);
  endtask

  task automatic wait_strobe(input int max, input string tag, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (key_valid !== 1'b1 && cnt < max);
    chk(tag, key_valid, 1);
  endtask

  task automatic wait_held_low(input int max, input string tag, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (key_held !== 1'b0 && cnt < max);
    chk(tag, key_held, 0);
  endtask

  // Scoreboard: every strobe must have been announced, carry the queued
  // code, and never follow another strobe directly.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      chk("strobe_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("strobe_code", key_code, exp_q.pop_front());
      chk("strobe_single_cycle", prev_valid, 0);
    end
    prev_valid <= key_valid;
  end

  initial begin
    mode = 0;
    rst  = 1'b1;
    ticks(3);
    chk("rst_col", col_dec, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_code", key_code, 0);

    // Column walk with no key pressed
    rst = 1'b0;
    for (int i = 0; i < 3 * SCAN; i++) begin
      chk("col_walk", col_dec, (i / SCAN_DIV) % 4);
      @(negedge clk);
    end

    // Single press, aligned to the start of a scan
    wait_scan_start();
    mode = 1;
    exp_q.push_back(4'h6);
    wait_strobe(LAT_MAX, "press1_strobe", n);
    chk("press1_latency", (n > SCAN && n <= 35), 1);
    @(negedge clk);
    chk("press1_held", key_held, 1);
    ticks(SCAN);
    chk("press1_still_held", key_held, 1);

    // Release, then press again
    mode = 0;
    wait_held_low(4 * SCAN, "release1_held", n);
    chk("release1_latency", (n > SCAN && n <= 3 * SCAN), 1);
    chk("code_holds", key_code, 4'h6);
    mode = 1;
    exp_q.push_back(4'h6);
    wait_strobe(LAT_MAX, "press2_strobe", n);
    mode = 0;
    wait_held_low(4 * SCAN, "release2_held", n);

    // Bounce: pressed / open / pressed, one scan each, then held
    wait_scan_start();
    mode = 1;
    ticks(SCAN);
    mode = 0;
    ticks(SCAN);
    mode = 1;
    ticks(SCAN);
    chk("bounce_no_strobe", exp_q.size(), 0);
    exp_q.push_back(4'h6);
    wait_strobe(LAT_MAX, "bounce_strobe", n);
    chk("bounce_latency", (n >= SCAN && n <= SCAN + 3), 1);
    mode = 0;
    wait_held_low(4 * SCAN, "bounce_release", n);

    // Two keys together are never accepted
    mode = 2;
    ticks(4 * SCAN);
    chk("multi_held", key_held, 0);
    chk("multi_no_strobe", exp_q.size(), 0);
    mode = 0;
    ticks(SCAN);

    // Reset in the middle of debouncing
    wait_scan_start();
    mode = 1;
    ticks(SCAN + SCAN / 2);
    rst = 1'b1;
    #1;
    chk("midrst_valid", key_valid, 0);
    chk("midrst_held", key_held, 0);
    chk("midrst_code", key_code, 0);
    chk("midrst_col", col_dec, 0);
    mode = 0;
    ticks(2);
    rst = 1'b0;
    ticks(3 * SCAN);
    chk("midrst_no_strobe", exp_q.size(), 0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: accept, then RDELAY scans later, then every RRATE scans
    wait_scan_start();
    mode = 1;
    repeat (4) exp_q.push_back(4'h6);
    wait_strobe(LAT_MAX, "rep_accept", n);
    chk("rep_accept_latency", (n > SCAN && n <= 35), 1);
    wait_strobe(RDELAY * SCAN + 4, "rep_first", n);
    chk("rep_first_gap", n, RDELAY * SCAN);
    wait_strobe(RRATE * SCAN + 4, "rep_second", n);
    chk("rep_second_gap", n, RRATE * SCAN);
    wait_strobe(RRATE * SCAN + 4, "rep_third", n);
    chk("rep_third_gap", n, RRATE * SCAN);
    mode = 0;
    wait_held_low(4 * SCAN, "rep_release", n);
`else
    // Long hold gives one strobe only
    wait_scan_start();
    mode = 1;
    exp_q.push_back(4'h6);
    wait_strobe(LAT_MAX, "hold_strobe", n);
    ticks(8 * SCAN);
    chk("hold_held", key_held, 1);
    mode = 0;
    wait_held_low(4 * SCAN, "hold_release", n);
`endif

    ticks(2 * SCAN);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x4 matrix keypad that supplies operands and commands to the FP MAC top level.
- Drives one column low at a time and leaves the others high-Z.
- Samples the active-low rows, debounces over whole scans, and emits a one-cycle key strobe with a 4-bit key code.
- Sits between the board keypad pins (key_col/key_row) and the MAC operand-entry logic.

Parameters:
- SCAN_DIV, 1000, clk cycles each column is driven (dwell); min 4; 20 us at 50 MHz.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; min 1.
- REPEAT_DELAY_SCANS, 200, full scans held before the first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_RATE_SCANS, 50, full scans between later auto-repeats (KEYPAD_REPEAT_EN only).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_row  input  4  keypad rows, active low, pulled up externally, asynchronous to clk.
- key_col  output  4  keypad columns: the active column drives 0, all others are high-Z.
- key_valid  output  1  one-cycle strobe; key_code is valid in the same cycle.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the accepted key.
- key_held  output  1  high while the accepted key is debounced-pressed.

Behaviour:
- Reset (async, rst=1):
  - col_idx=0, so key_col=4'bzzz0.
  - dwell counter=0, FSM=IDLE.
  - key_valid=0, key_code=0, key_held=0.
  - row synchronizer = 4'hF.
- Row sync:
  - key_row passes through 2 flops before use.
  - The synchronized row is sampled once per column, on the last dwell cycle (count==SCAN_DIV-1).
- Column scan:
  - Columns are driven in order 0,1,2,3, then wrap to 0.
  - key_col[c]=0 when col_idx==c; every other bit is z.
  - col_idx advances on the cycle after the sample.
- Scan result:
  - Evaluated at the end of column 3's dwell.
  - Classified as NONE (no row low in any column), ONE (exactly one row/col pair low), or MULTI.
  - ONE yields cand_code={row_idx,col_idx}.
- FSM, one transition per completed scan:
  - IDLE:
    - ONE -> DEBOUNCE; cand=code, match_cnt=1.
    - NONE or MULTI -> stay.
  - DEBOUNCE:
    - ONE with the same code: match_cnt++.
    - When match_cnt reaches DEBOUNCE_SCANS -> PRESSED; key_code=cand, key_valid=1 for exactly one clk.
    - ONE with a different code: restart with the new cand, match_cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED:
    - key_held=1.
    - Scans returning the same code reset rel_cnt.
    - NONE increments rel_cnt; when rel_cnt reaches DEBOUNCE_SCANS -> IDLE and key_held=0.
    - MULTI or a different code: hold state, no new strobe; the key must be released first (no rollover).
- Corner cases:
  - With DEBOUNCE_SCANS=1, the strobe fires at the end of the first scan that sees the key.
  - Latency from a stable press to key_valid is at most (DEBOUNCE_SCANS+1) x 4 x SCAN_DIV + 3 cycles.
  - key_code holds its value until the next accepted key.
  - Reset mid-scan aborts immediately: no strobe, key_held=0, scanning restarts at column 0.
  - key_valid is never high for two consecutive cycles.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter counts completed scans whose result matches key_code.
  - It pulses key_valid, with key_code unchanged, after REPEAT_DELAY_SCANS matching scans, then every REPEAT_RATE_SCANS.
  - The counter clears on leaving PRESSED.
- Undefined:
  - Exactly one key_valid per press.
  - REPEAT_* parameters are ignored.
  - No repeat counter logic is synthesized.

Test Plan:
- Reset/idle: SCAN_DIV=4, DEBOUNCE_SCANS=2, rst pulse, key_row=4'hF.
  - Required: key_col=4'bzzz0 during reset.
  - Required: key_col walks zzz0, zz0z, z0zz, 0zzz, 4 cycles each, repeating.
  - Required: key_valid never asserts.
- Single press: bench model returns key_row=4'b1101 while key_col===4'bz0zz.
  - Required: exactly one key_valid with key_code=4'h6.
  - Required: the strobe arrives at the end of the 2nd full scan (<=35 cycles after the first sampled press); key_held=1 afterwards.
- Release: drop the row back to 4'hF.
  - Required: key_held falls after 2 empty scans.
  - Required: pressing again produces a second strobe with code 4'h6.
- Bounce: toggle the row every scan for 3 scans, then hold.
  - Required: no strobe during the toggling.
  - Required: one strobe, code 4'h6, after 2 stable scans.
- Multi-key and mid-operation reset: rows 1 and 2 low (code 4'h6 and 4'h9 pressed together).
  - Required: no strobe.
  - Asserting rst mid-debounce clears state; key_valid=0 and key_held=0 immediately.
- KEYPAD_REPEAT_EN defined, REPEAT_DELAY_SCANS=3, REPEAT_RATE_SCANS=2: hold key 4'h6.
  - Required: strobes after 2 scans (accept), then 3 scans later, then every 2 scans.
  - Required: all strobes have key_code=4'h6.
